// File: rtl/ctrl_fsm_if.sv
// Control bundle between the multi-cycle control FSM (master) and the fetch/datapath (slave).
interface ctrl_fsm_if;
  logic        flag;
  logic [28:1] IR;
  logic        Write_IR;
  logic        Write_PC;
  logic [1:0]  PC_s;
  logic [3:0]  ALU_OP;
  logic        Imm_sel;
  logic        Write_F;
  logic        Write_NZCV;
  logic        Write_Reg;
  logic        Rd_LR_sel;
  logic        Wdata_PC_sel;
  logic        illegal;
  logic [3:0]  State;

  modport master (
    input  flag, IR,
    output Write_IR, Write_PC, PC_s, ALU_OP, Imm_sel, Write_F, Write_NZCV,
           Write_Reg, Rd_LR_sel, Wdata_PC_sel, illegal, State
  );

  modport slave (
    output flag, IR,
    input  Write_IR, Write_PC, PC_s, ALU_OP, Imm_sel, Write_F, Write_NZCV,
           Write_Reg, Rd_LR_sel, Wdata_PC_sel, illegal, State
  );
endinterface

// File: rtl/ctrl_fsm.sv
// Multi-cycle control unit: fetch/decode/execute/write-back sequencing for DP and B/BL.
// All control outputs are Moore decodes of the current state and the latched IR.
module ctrl_fsm #(
  parameter int unsigned ROM_WAIT     = 0,
  parameter bit          ILLEGAL_HALT = 1'b0
) (
  input logic       clk,
  input logic       Rst_n,
  ctrl_fsm_if.master bus
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] WAIT   = 4'd1;
  localparam logic [3:0] FETCH  = 4'd2;
  localparam logic [3:0] DECODE = 4'd3;
  localparam logic [3:0] EXE    = 4'd4;
  localparam logic [3:0] WB     = 4'd5;
  localparam logic [3:0] LINK   = 4'd6;
  localparam logic [3:0] BRANCH = 4'd7;
  localparam logic [3:0] HALT   = 4'd8;

  // Entry point for every new instruction: ROM settle time first, if any.
  localparam logic [3:0] NEXT_FETCH = (ROM_WAIT > 0) ? WAIT : FETCH;
  localparam logic [3:0] WAIT_LAST  = (ROM_WAIT > 0) ? 4'(ROM_WAIT - 1) : 4'd0;

  logic [3:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic is_dp, is_br, is_link, is_cmp, rd_pc;
  logic unused_ir;

  assign is_dp     = (bus.IR[28:27] == 2'b00);
  assign is_br     = (bus.IR[28:26] == 3'b101);
  assign is_link   = bus.IR[25];
  assign is_cmp    = (bus.IR[25:24] == 2'b10);
  assign rd_pc     = (bus.IR[16:13] == 4'hF);
  assign unused_ir = ^{bus.IR[20:17], bus.IR[12:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = 4'd0;
    case (state_q)
      IDLE:   state_d = NEXT_FETCH;
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      // A failed condition still advanced PC, so just move on to the next word.
      FETCH:  state_d = bus.flag ? DECODE : NEXT_FETCH;
      DECODE: begin
        if (is_dp) begin
          state_d = EXE;
        end else if (is_br) begin
          state_d = is_link ? LINK : BRANCH;
        end else begin
          state_d = ILLEGAL_HALT ? HALT : NEXT_FETCH;
        end
      end
      EXE:    state_d = WB;
      WB:     state_d = NEXT_FETCH;
      LINK:   state_d = BRANCH;
      BRANCH: state_d = NEXT_FETCH;
      HALT:   state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.Write_IR     = 1'b0;
    bus.Write_PC     = 1'b0;
    bus.PC_s         = 2'b00;
    bus.ALU_OP       = 4'd0;
    bus.Imm_sel      = 1'b0;
    bus.Write_F      = 1'b0;
    bus.Write_NZCV   = 1'b0;
    bus.Write_Reg    = 1'b0;
    bus.Rd_LR_sel    = 1'b0;
    bus.Wdata_PC_sel = 1'b0;
    bus.illegal      = 1'b0;
    case (state_q)
      FETCH: begin
        bus.Write_IR = 1'b1;
        bus.Write_PC = 1'b1;
      end
      DECODE: bus.illegal = !is_dp && !is_br;
      EXE: begin
        bus.ALU_OP     = bus.IR[25:22];
        bus.Imm_sel    = bus.IR[26];
        bus.Write_F    = 1'b1;
        bus.Write_NZCV = bus.IR[21];
      end
      WB: begin
        // TST/TEQ/CMP/CMN only update flags, which already happened in EXE.
        if (!is_cmp) begin
          if (rd_pc) begin
            bus.Write_PC = 1'b1;
            bus.PC_s     = 2'b10;
          end else begin
            bus.Write_Reg = 1'b1;
          end
        end
      end
      LINK: begin
        bus.Write_Reg    = 1'b1;
        bus.Rd_LR_sel    = 1'b1;
        bus.Wdata_PC_sel = 1'b1;
      end
      BRANCH: begin
        bus.Write_PC = 1'b1;
        bus.PC_s     = 2'b01;
      end
      default: ;
    endcase
  end

  assign bus.State = state_q;

endmodule
